// File: rtl/dlx_ctrl_pkg.sv
// rtl/dlx_ctrl_pkg.sv - state, opcode and operand-select encodings for the DLX control FSM
package dlx_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH       = 5'd0,
    S_DECODE      = 5'd1,
    S_SHIFT       = 5'd2,
    S_ALU         = 5'd3,
    S_PALU        = 5'd4,
    S_ALUI        = 5'd5,
    S_TESTI       = 5'd6,
    S_ADDRCMP     = 5'd7,
    S_LOAD        = 5'd8,
    S_COPYMDR2C   = 5'd9,
    S_COPYGPR2MDR = 5'd10,
    S_STORE       = 5'd11,
    S_BRANCH      = 5'd12,
    S_BTAKEN      = 5'd13,
    S_JR          = 5'd14,
    S_SAVEPC      = 5'd15,
    S_JALR        = 5'd16,
    S_WBR         = 5'd17,
    S_WBI         = 5'd18,
    S_WBJ         = 5'd19,
    S_HALT        = 5'd20
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_PALU  = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQZ  = 6'b000100;
  localparam logic [5:0] OP_BNEZ  = 6'b000101;
  localparam logic [5:0] OP_JR    = 6'b010110;
  localparam logic [5:0] OP_JALR  = 6'b010111;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] S1_PC   = 2'd0;
  localparam logic [1:0] S1_A    = 2'd1;
  localparam logic [1:0] S1_B    = 2'd2;
  localparam logic [1:0] S1_MDR  = 2'd3;

  localparam logic [1:0] S2_B    = 2'd0;
  localparam logic [1:0] S2_IMM  = 2'd1;
  localparam logic [1:0] S2_ZERO = 2'd2;
  localparam logic [1:0] S2_ONE  = 2'd3;

endpackage

// File: rtl/dlx_opcode_decode.sv
// rtl/dlx_opcode_decode.sv - maps opcode/func bits to the state that follows DECODE
module dlx_opcode_decode
  import dlx_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       func5,
  output state_t     next_state
);

  always_comb begin
    next_state = S_HALT;
    if (opcode == OP_RTYPE)
      next_state = func5 ? S_ALU : S_SHIFT;
    else if (opcode == OP_PALU)
      next_state = S_PALU;
    else if (opcode[5:3] == 3'b001)
      next_state = S_ALUI;
    else if (opcode[5:3] == 3'b011)
      next_state = S_TESTI;
    else if (opcode == OP_LW || opcode == OP_SW)
      next_state = S_ADDRCMP;
    else if (opcode == OP_BEQZ || opcode == OP_BNEZ)
      next_state = S_BRANCH;
    else if (opcode == OP_JR)
      next_state = S_JR;
    else if (opcode == OP_JALR)
      next_state = S_SAVEPC;
  end

endmodule

// File: rtl/dlx_control_fsm.sv
// rtl/dlx_control_fsm.sv - multicycle Moore control unit sequencing the DLX datapath
module dlx_control_fsm
  import dlx_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic        AEQZ,
  input  logic        ACK,
  output logic        IR_CE,
  output logic        A_CE,
  output logic        B_CE,
  output logic        C_CE,
  output logic        MDR_CE,
  output logic        MAR_CE,
  output logic        PC_CE,
  output logic        GPR_WE,
  output logic [1:0]  S1_SEL,
  output logic [1:0]  S2_SEL,
  output logic        ITYPE,
  output logic        ADD,
  output logic        TEST,
  output logic        SHIFT,
  output logic        RIGHT,
  output logic        JLINK,
  output logic        DINT_SEL,
  output logic        MDR_SEL,
  output logic        A_SEL,
  output logic        MUXALU_SEL,
  output logic        MR,
  output logic        MW,
  output logic        HALTED,
  output logic [4:0]  STATE
);

  state_t     state, next_state, decode_next;
  logic [5:0] opcode;
  logic       branch_taken;
  logic       unused_ir_bits;

  assign opcode         = IR[31:26];
  assign unused_ir_bits = ^{IR[25:6], IR[4:2], IR[0]};
  assign branch_taken   = (opcode == OP_BEQZ) ? AEQZ : !AEQZ;
  assign STATE          = state;

  dlx_opcode_decode u_decode (
    .opcode     (opcode),
    .func5      (IR[5]),
    .next_state (decode_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= S_FETCH;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:       next_state = ACK ? S_DECODE : S_FETCH;
      S_DECODE:      next_state = decode_next;
      S_SHIFT,
      S_ALU,
      S_PALU:        next_state = S_WBR;
      S_ALUI,
      S_TESTI:       next_state = S_WBI;
      S_ADDRCMP:     next_state = (opcode == OP_LW) ? S_LOAD : S_COPYGPR2MDR;
      S_LOAD:        next_state = ACK ? S_COPYMDR2C : S_LOAD;
      S_COPYMDR2C:   next_state = S_WBI;
      S_COPYGPR2MDR: next_state = S_STORE;
      S_STORE:       next_state = ACK ? S_FETCH : S_STORE;
      S_BRANCH:      next_state = branch_taken ? S_BTAKEN : S_FETCH;
      S_SAVEPC:      next_state = S_JALR;
      S_JALR:        next_state = S_WBJ;
      S_HALT:        next_state = S_HALT;
      default:       next_state = S_FETCH;
    endcase
  end

  // Only IR_CE and MDR_CE look at ACK directly; everything else is pure state decode.
  always_comb begin
    IR_CE = 1'b0; A_CE = 1'b0; B_CE = 1'b0; C_CE = 1'b0;
    MDR_CE = 1'b0; MAR_CE = 1'b0; PC_CE = 1'b0; GPR_WE = 1'b0;
    S1_SEL = S1_PC; S2_SEL = S2_B;
    ITYPE = 1'b0; ADD = 1'b0; TEST = 1'b0; SHIFT = 1'b0; RIGHT = 1'b0; JLINK = 1'b0;
    DINT_SEL = 1'b0; MDR_SEL = 1'b0; A_SEL = 1'b0; MUXALU_SEL = 1'b0;
    MR = 1'b0; MW = 1'b0; HALTED = 1'b0;
    case (state)
      S_FETCH: begin
        MR = 1'b1; IR_CE = ACK;
      end
      S_DECODE: begin
        A_CE = 1'b1; B_CE = 1'b1; PC_CE = 1'b1;
        S1_SEL = S1_PC; S2_SEL = S2_ONE; ADD = 1'b1;
      end
      S_SHIFT: begin
        S1_SEL = S1_A; SHIFT = 1'b1; RIGHT = IR[1]; DINT_SEL = 1'b1; C_CE = 1'b1;
      end
      S_ALU: begin
        S1_SEL = S1_A; S2_SEL = S2_B; C_CE = 1'b1;
      end
      S_PALU: begin
        S1_SEL = S1_A; S2_SEL = S2_B; MUXALU_SEL = 1'b1; C_CE = 1'b1;
      end
      S_ALUI: begin
        S1_SEL = S1_A; S2_SEL = S2_IMM; ITYPE = 1'b1; C_CE = 1'b1;
      end
      S_TESTI: begin
        S1_SEL = S1_A; S2_SEL = S2_IMM; ITYPE = 1'b1; TEST = 1'b1; C_CE = 1'b1;
      end
      S_ADDRCMP: begin
        S1_SEL = S1_A; S2_SEL = S2_IMM; ADD = 1'b1; MAR_CE = 1'b1;
      end
      S_LOAD: begin
        MR = 1'b1; A_SEL = 1'b1; MDR_SEL = 1'b1; MDR_CE = ACK;
      end
      S_COPYMDR2C: begin
        S1_SEL = S1_MDR; S2_SEL = S2_ZERO; ADD = 1'b1; C_CE = 1'b1;
      end
      S_COPYGPR2MDR: begin
        S1_SEL = S1_B; S2_SEL = S2_ZERO; ADD = 1'b1; MDR_CE = 1'b1;
      end
      S_STORE: begin
        MW = 1'b1; A_SEL = 1'b1;
      end
      S_BTAKEN: begin
        S1_SEL = S1_PC; S2_SEL = S2_IMM; ADD = 1'b1; PC_CE = 1'b1;
      end
      S_JR, S_JALR: begin
        S1_SEL = S1_A; S2_SEL = S2_ZERO; ADD = 1'b1; PC_CE = 1'b1;
      end
      S_SAVEPC: begin
        S1_SEL = S1_PC; S2_SEL = S2_ZERO; ADD = 1'b1; C_CE = 1'b1;
      end
      S_WBR: GPR_WE = 1'b1;
      S_WBI: begin
        GPR_WE = 1'b1; ITYPE = 1'b1;
      end
      S_WBJ: begin
        GPR_WE = 1'b1; JLINK = 1'b1;
      end
      S_HALT: HALTED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dlx_control_fsm.sv
// tb/tb_dlx_control_fsm.sv - per-cycle vector table and scoreboard bench for dlx_control_fsm
module tb_dlx_control_fsm;
  import dlx_ctrl_pkg::*;

  logic        CLK, RESET, AEQZ, ACK;
  logic [31:0] IR;
  logic        IR_CE, A_CE, B_CE, C_CE, MDR_CE, MAR_CE, PC_CE, GPR_WE;
  logic [1:0]  S1_SEL, S2_SEL;
  logic        ITYPE, ADD, TEST, SHIFT, RIGHT, JLINK;
  logic        DINT_SEL, MDR_SEL, A_SEL, MUXALU_SEL, MR, MW, HALTED;
  logic [4:0]  STATE;

  dlx_control_fsm dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .AEQZ(AEQZ), .ACK(ACK),
    .IR_CE(IR_CE), .A_CE(A_CE), .B_CE(B_CE), .C_CE(C_CE), .MDR_CE(MDR_CE),
    .MAR_CE(MAR_CE), .PC_CE(PC_CE), .GPR_WE(GPR_WE),
    .S1_SEL(S1_SEL), .S2_SEL(S2_SEL),
    .ITYPE(ITYPE), .ADD(ADD), .TEST(TEST), .SHIFT(SHIFT), .RIGHT(RIGHT), .JLINK(JLINK),
    .DINT_SEL(DINT_SEL), .MDR_SEL(MDR_SEL), .A_SEL(A_SEL), .MUXALU_SEL(MUXALU_SEL),
    .MR(MR), .MW(MW), .HALTED(HALTED), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ir_ce, a_ce, b_ce, c_ce, mdr_ce, mar_ce, pc_ce, gpr_we;
    logic [1:0] s1, s2;
    logic       itype, add, test, shift, right, jlink;
    logic       dint_sel, mdr_sel, a_sel, muxalu_sel, mr, mw, halted;
  } ctrl_t;

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic        ack;
    logic        aeqz;
    state_t      st;
  } vec_t;

  typedef struct {
    state_t st;
    ctrl_t  c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_SRL  = 32'h0022_1802;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0004;
  localparam logic [31:0] I_BEQZ = 32'h1020_0004;
  localparam logic [31:0] I_BNEZ = 32'h1420_0004;
  localparam logic [31:0] I_ADDI = 32'h2022_0005;
  localparam logic [31:0] I_TSTI = 32'h6C22_0005;
  localparam logic [31:0] I_PALU = 32'hC022_1820;
  localparam logic [31:0] I_JR   = 32'h5820_0000;
  localparam logic [31:0] I_JALR = 32'h5C20_0000;
  localparam logic [31:0] I_UNDF = 32'hF800_0000;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  // Expected control word for a state, written from the datapath control table.
  function automatic ctrl_t exp_ctrl(state_t st, logic ack, logic [31:0] ir);
    ctrl_t c = '0;
    case (st)
      S_FETCH:       begin c.mr = 1; c.ir_ce = ack; end
      S_DECODE:      begin c.a_ce = 1; c.b_ce = 1; c.pc_ce = 1; c.s1 = 0; c.s2 = 3; c.add = 1; end
      S_SHIFT:       begin c.s1 = 1; c.shift = 1; c.right = ir[1]; c.dint_sel = 1; c.c_ce = 1; end
      S_ALU:         begin c.s1 = 1; c.s2 = 0; c.c_ce = 1; end
      S_PALU:        begin c.s1 = 1; c.s2 = 0; c.muxalu_sel = 1; c.c_ce = 1; end
      S_ALUI:        begin c.s1 = 1; c.s2 = 1; c.itype = 1; c.c_ce = 1; end
      S_TESTI:       begin c.s1 = 1; c.s2 = 1; c.itype = 1; c.test = 1; c.c_ce = 1; end
      S_ADDRCMP:     begin c.s1 = 1; c.s2 = 1; c.add = 1; c.mar_ce = 1; end
      S_LOAD:        begin c.mr = 1; c.a_sel = 1; c.mdr_sel = 1; c.mdr_ce = ack; end
      S_COPYMDR2C:   begin c.s1 = 3; c.s2 = 2; c.add = 1; c.c_ce = 1; end
      S_COPYGPR2MDR: begin c.s1 = 2; c.s2 = 2; c.add = 1; c.mdr_ce = 1; end
      S_STORE:       begin c.mw = 1; c.a_sel = 1; end
      S_BTAKEN:      begin c.s1 = 0; c.s2 = 1; c.add = 1; c.pc_ce = 1; end
      S_JR, S_JALR:  begin c.s1 = 1; c.s2 = 2; c.add = 1; c.pc_ce = 1; end
      S_SAVEPC:      begin c.s1 = 0; c.s2 = 2; c.add = 1; c.c_ce = 1; end
      S_WBR:         c.gpr_we = 1;
      S_WBI:         begin c.gpr_we = 1; c.itype = 1; end
      S_WBJ:         begin c.gpr_we = 1; c.jlink = 1; end
      S_HALT:        c.halted = 1;
      default:       c = '0;
    endcase
    return c;
  endfunction

  task automatic add(input logic rst, input logic [31:0] ir, input logic ack,
                     input logic aeqz, input state_t st);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ack = ack; v.aeqz = aeqz; v.st = st;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, record the expectation, then compare mid-cycle.
  task automatic step(input vec_t v);
    exp_t  e;
    ctrl_t got;
    @(negedge CLK);
    RESET = v.rst; IR = v.ir; ACK = v.ack; AEQZ = v.aeqz;
    e.st = v.st;
    e.c  = exp_ctrl(v.st, v.ack, v.ir);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    got = {IR_CE, A_CE, B_CE, C_CE, MDR_CE, MAR_CE, PC_CE, GPR_WE, S1_SEL, S2_SEL,
           ITYPE, ADD, TEST, SHIFT, RIGHT, JLINK,
           DINT_SEL, MDR_SEL, A_SEL, MUXALU_SEL, MR, MW, HALTED};
    checks++;
    if (STATE !== e.st) begin
      failures++;
      $display("FAIL state step=%0d got=%0d exp=%0d", step_no, STATE, e.st);
    end
    checks++;
    if (got !== e.c) begin
      failures++;
      $display("FAIL ctrl step=%0d state=%0d got=%07h exp=%07h", step_no, e.st, got, e.c);
    end
    step_no++;
  endtask

  task automatic hs(input logic rst, input logic [31:0] ir, input logic ack,
                    input logic aeqz, input state_t st);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ack = ack; v.aeqz = aeqz; v.st = st;
    step(v);
  endtask

  initial begin
    RESET = 1'b1; IR = '0; ACK = 1'b0; AEQZ = 1'b0;

    // R-type ADD; ACK in ALU must be ignored
    add(0, I_ADD, 1, 0, S_FETCH); add(0, I_ADD, 0, 0, S_DECODE);
    add(0, I_ADD, 1, 0, S_ALU);   add(0, I_ADD, 0, 0, S_WBR);
    // SRL: right shift
    add(0, I_SRL, 1, 0, S_FETCH); add(0, I_SRL, 0, 0, S_DECODE);
    add(0, I_SRL, 0, 0, S_SHIFT); add(0, I_SRL, 0, 0, S_WBR);
    // LW with three wait cycles in LOAD
    add(0, I_LW, 1, 0, S_FETCH);  add(0, I_LW, 0, 0, S_DECODE);
    add(0, I_LW, 0, 0, S_ADDRCMP);
    for (int i = 0; i < 3; i++) add(0, I_LW, 0, 0, S_LOAD);
    add(0, I_LW, 1, 0, S_LOAD);   add(0, I_LW, 0, 0, S_COPYMDR2C);
    add(0, I_LW, 0, 0, S_WBI);
    // SW with one fetch wait cycle
    add(0, I_SW, 0, 0, S_FETCH);  add(0, I_SW, 1, 0, S_FETCH);
    add(0, I_SW, 0, 0, S_DECODE); add(0, I_SW, 0, 0, S_ADDRCMP);
    add(0, I_SW, 0, 0, S_COPYGPR2MDR); add(0, I_SW, 1, 0, S_STORE);
    // branches, taken and not taken
    add(0, I_BEQZ, 1, 1, S_FETCH); add(0, I_BEQZ, 0, 1, S_DECODE);
    add(0, I_BEQZ, 0, 1, S_BRANCH); add(0, I_BEQZ, 0, 1, S_BTAKEN);
    add(0, I_BEQZ, 1, 0, S_FETCH); add(0, I_BEQZ, 0, 0, S_DECODE);
    add(0, I_BEQZ, 0, 0, S_BRANCH);
    add(0, I_BNEZ, 1, 0, S_FETCH); add(0, I_BNEZ, 0, 0, S_DECODE);
    add(0, I_BNEZ, 0, 0, S_BRANCH); add(0, I_BNEZ, 0, 0, S_BTAKEN);
    add(0, I_BNEZ, 1, 1, S_FETCH); add(0, I_BNEZ, 0, 1, S_DECODE);
    add(0, I_BNEZ, 0, 1, S_BRANCH);
    // immediate ALU and test
    add(0, I_ADDI, 1, 0, S_FETCH); add(0, I_ADDI, 0, 0, S_DECODE);
    add(0, I_ADDI, 0, 0, S_ALUI);  add(0, I_ADDI, 0, 0, S_WBI);
    add(0, I_TSTI, 1, 0, S_FETCH); add(0, I_TSTI, 0, 0, S_DECODE);
    add(0, I_TSTI, 0, 0, S_TESTI); add(0, I_TSTI, 0, 0, S_WBI);
    // parallel ALU
    add(0, I_PALU, 1, 0, S_FETCH); add(0, I_PALU, 0, 0, S_DECODE);
    add(0, I_PALU, 0, 0, S_PALU);  add(0, I_PALU, 0, 0, S_WBR);
    // jumps
    add(0, I_JR, 1, 0, S_FETCH);   add(0, I_JR, 0, 0, S_DECODE);
    add(0, I_JR, 0, 0, S_JR);
    add(0, I_JALR, 1, 0, S_FETCH); add(0, I_JALR, 0, 0, S_DECODE);
    add(0, I_JALR, 0, 0, S_SAVEPC); add(0, I_JALR, 0, 0, S_JALR);
    add(0, I_JALR, 0, 0, S_WBJ);
    // undefined opcode halts; ACK toggling must not release it, only reset does
    add(0, I_UNDF, 1, 0, S_FETCH); add(0, I_UNDF, 0, 0, S_DECODE);
    for (int i = 0; i < 10; i++) add(0, I_UNDF, 1'(i % 2), 0, S_HALT);
    add(1, I_UNDF, 0, 0, S_HALT);
    add(0, I_HALT, 1, 0, S_FETCH); add(0, I_HALT, 0, 0, S_DECODE);
    add(0, I_HALT, 1, 0, S_HALT);  add(1, I_HALT, 0, 0, S_HALT);

    @(posedge CLK);
    hs(1, 32'h0, 0, 0, S_FETCH);

    foreach (vecs[i]) step(vecs[i]);
    hs(0, I_ADD, 0, 0, S_FETCH);

    // reset during the second STORE wait cycle must abort the write
    hs(0, I_SW, 1, 0, S_FETCH);   hs(0, I_SW, 0, 0, S_DECODE);
    hs(0, I_SW, 0, 0, S_ADDRCMP); hs(0, I_SW, 0, 0, S_COPYGPR2MDR);
    hs(0, I_SW, 0, 0, S_STORE);   hs(1, I_SW, 0, 0, S_STORE);
    hs(0, I_SW, 0, 0, S_FETCH);

    // reset during a LOAD wait must not let the load sequence continue
    hs(0, I_LW, 1, 0, S_FETCH);   hs(0, I_LW, 0, 0, S_DECODE);
    hs(0, I_LW, 0, 0, S_ADDRCMP); hs(1, I_LW, 1, 0, S_LOAD);
    hs(0, I_LW, 0, 0, S_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
